// File: rtl/dac_pkg.sv
// Shared types and constants for the codec DAC playback path and its LRC edge helper.
// Pure declarations; no latency, no backpressure.
package dac_pkg;
  localparam int SAMPLE_W = 16;
  localparam int ADDR_W   = 18;
  localparam int CNT_W    = 5;

  localparam logic [1:0] LRC_FALL = 2'b10;
  localparam logic [1:0] LRC_RISE = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LRC,
    SHIFT,
    DONE
  } state_t;
endpackage

// File: rtl/dac_player_if.sv
// Codec DAC lines plus SRAM read strobe/data between the player and the board.
// Wires only; no latency, no backpressure.
interface dac_player_if;
  logic                         daclrc;
  logic                         dacdat;
  logic                         read;
  logic [dac_pkg::SAMPLE_W-1:0] sram_rdata;

  modport master (
    input  daclrc,
    input  sram_rdata,
    output dacdat,
    output read
  );

  modport slave (
    output daclrc,
    output sram_rdata,
    input  dacdat,
    input  read
  );
endinterface

// File: rtl/audio_lrc_edge.sv
// Two-deep LRC history with fall/rise decode; shared by playback and recording.
// fall/rise are valid the cycle after the first posedge that samples the new level; no backpressure.
module audio_lrc_edge
  import dac_pkg::*;
(
  input  logic bclk,
  input  logic reset,
  input  logic lrc,
  output logic fall,
  output logic rise
);

  logic [1:0] lrc_hist_q;
  logic [1:0] lrc_hist_d;

  always_comb begin
    lrc_hist_d = {lrc_hist_q[0], lrc};
  end

  always_ff @(posedge bclk) begin
    if (reset) begin
      lrc_hist_q <= 2'b00;
    end else begin
      lrc_hist_q <= lrc_hist_d;
    end
  end

  assign fall = (lrc_hist_q == LRC_FALL);
  assign rise = (lrc_hist_q == LRC_RISE);

endmodule

// File: rtl/dac_player.sv
// Plays 16-bit mono SRAM samples LSB-first on both codec slots; DAC_LOOP_EN wraps at end_addr.
// First bit two bclk after daclrc falls; no backpressure, play=0 pauses and releases addr.
module dac_player
  import dac_pkg::*;
(
  input  logic              bclk,
  input  logic              reset,
  input  logic              play,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              done,
  output wire  [ADDR_W-1:0] addr,
  dac_player_if.master      dac
);

  logic fall;
  logic rise;

  audio_lrc_edge u_lrc_edge (
    .bclk  (bclk),
    .reset (reset),
    .lrc   (dac.daclrc),
    .fall  (fall),
    .rise  (rise)
  );

  state_t              state_q, state_d;
  logic [SAMPLE_W-1:0] sh_q, sh_d;
  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_buffer_q, addr_buffer_d;
  logic                dacdat_q, dacdat_d;
  logic                done_q, done_d;

  logic                load;
  logic [SAMPLE_W-1:0] load_src;

  always_comb begin
    state_d       = state_q;
    sh_d          = sh_q;
    hold_d        = hold_q;
    cnt_d         = cnt_q;
    addr_buffer_d = addr_buffer_q;
    dacdat_d      = 1'b0;
    done_d        = 1'b0;
    load          = 1'b0;
    load_src      = hold_q;

    case (state_q)
      IDLE: begin
        if (play) begin
          state_d = WAIT_LRC;
        end
      end

      WAIT_LRC: begin
        if (!play) begin
          state_d = IDLE;
        end else if (fall) begin
          load     = 1'b1;
          load_src = dac.sram_rdata;
          hold_d   = dac.sram_rdata;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        if (!play) begin
          state_d = IDLE;
        end else if (fall) begin
          load     = 1'b1;
          load_src = dac.sram_rdata;
          hold_d   = dac.sram_rdata;
        end else if (rise) begin
          // Right slot replays the held left sample while addr moves on,
          // giving the SRAM the rest of the frame to settle.
          if (addr_buffer_q == end_addr) begin
`ifdef DAC_LOOP_EN
            addr_buffer_d = '0;
            done_d        = 1'b1;
            load          = 1'b1;
`else
            state_d       = DONE;
            done_d        = 1'b1;
`endif
          end else begin
            addr_buffer_d = addr_buffer_q + 1'b1;
            load          = 1'b1;
          end
        end else if (cnt_q < CNT_W'(SAMPLE_W)) begin
          dacdat_d = sh_q[cnt_q[3:0]];
          cnt_d    = cnt_q + 1'b1;
        end
      end

      DONE: begin
        done_d = play;
        if (!play) begin
          state_d       = IDLE;
          addr_buffer_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      sh_d     = load_src;
      dacdat_d = load_src[0];
      cnt_d    = CNT_W'(1);
    end
  end

  always_ff @(posedge bclk) begin
    if (reset) begin
      state_q       <= IDLE;
      sh_q          <= '0;
      hold_q        <= '0;
      cnt_q         <= '0;
      addr_buffer_q <= '0;
      dacdat_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sh_q          <= sh_d;
      hold_q        <= hold_d;
      cnt_q         <= cnt_d;
      addr_buffer_q <= addr_buffer_d;
      dacdat_q      <= dacdat_d;
      done_q        <= done_d;
    end
  end

  assign dac.dacdat = dacdat_q;
  assign dac.read   = play;
  assign done       = done_q;
  assign addr       = play ? addr_buffer_q : {ADDR_W{1'bz}};

endmodule

// File: tb/tb_dac_player.sv
// Directed bench for dac_player: framing, bit order, end-of-buffer, pause and reset.
// Outputs are logged 1ns after every posedge bclk and compared against hand-derived values.
module tb_dac_player;

  logic        bclk;
  logic        reset;
  logic        play;
  logic [17:0] end_addr;
  logic        done;
  wire  [17:0] addr;
  logic [15:0] rbase;

  dac_player_if dif ();

  dac_player dut (
    .bclk     (bclk),
    .reset    (reset),
    .play     (play),
    .end_addr (end_addr),
    .done     (done),
    .addr     (addr),
    .dac      (dif)
  );

  // SRAM model: word at address a is rbase ^ (a * 0x0F35)
  assign dif.sram_rdata = rbase ^ (addr[15:0] * 16'h0F35);

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  int   n_cmp = 0;
  int   n_mis = 0;
  int   ph    = 0;
  logic        log_dat  [0:511];
  logic [17:0] log_addr [0:511];
  logic        log_done [0:511];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic lrc);
    dif.daclrc = lrc;
    @(posedge bclk);
    #1;
    if (ph < 512) begin
      log_dat[ph]  = dif.dacdat;
      log_addr[ph] = addr;
      log_done[ph] = done;
    end
    ph++;
  endtask

  // 32-bclk frames: daclrc low for the first 16, high for the last 16
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      tick(((ph % 32) >= 16) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    play  = 1'b0;
    tick(1'b1);
    tick(1'b1);
    reset = 1'b0;
  endtask

  task automatic start_play();
    play = 1'b1;
    tick(1'b1);
    ph = 0;
  endtask

  function automatic logic [15:0] grab(input int s, input int n);
    logic [15:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[j] = log_dat[s + j];
    return r;
  endfunction

  function automatic logic [15:0] mem(input int a);
    logic [15:0] av;
    av = a[15:0];
    return rbase ^ (av * 16'h0F35);
  endfunction

  logic [15:0] m;
  int          done_cnt;

  initial begin
    reset      = 1'b1;
    play       = 1'b0;
    end_addr   = 18'd100;
    rbase      = 16'hA5C3;
    dif.daclrc = 1'b1;

    // Reset state
    do_reset();
    reset = 1'b1;
    tick(1'b1);
    tick(1'b1);
    check_val("rst_dacdat", 32'(dif.dacdat), 32'd0);
    check_val("rst_done",   32'(done),       32'd0);
    check_val("rst_read",   32'(dif.read),   32'd0);
    reset = 1'b0;

    // Single sample: A5C3 on both slots, addr steps at rise detect
    do_reset();
    end_addr = 18'd100;
    start_play();
    run(40);
    check_val("single_left",  32'(grab(1, 16)),  32'h0000A5C3);
    check_val("single_right", 32'(grab(17, 16)), 32'h0000A5C3);
    check_val("single_addr0", 32'(log_addr[16]), 32'd0);
    check_val("single_addr1", 32'(log_addr[17]), 32'd1);
    check_val("single_read",  32'(dif.read),     32'd1);

`ifdef DAC_LOOP_EN
    // Wrap: addr 0,1,2,0,1 and a single-cycle done at the wrap
    do_reset();
    end_addr = 18'd2;
    start_play();
    run(170);
    for (int f = 0; f < 5; f++) begin
      check_val($sformatf("wrap_addr_f%0d", f), 32'(log_addr[32*f + 16]), 32'((f % 3)));
    end
    done_cnt = 0;
    for (int i = 0; i < 170; i++) done_cnt += int'(log_done[i]);
    check_val("wrap_done_cnt", 32'(done_cnt),     32'd1);
    check_val("wrap_done_at",  32'(log_done[81]), 32'd1);
    check_val("wrap_right",    32'(grab(81, 16)), 32'(mem(2)));
`else
    // End stop: done rises at the third rise detect and holds
    do_reset();
    end_addr = 18'd2;
    start_play();
    run(100);
    check_val("end_done_before", 32'(log_done[80]), 32'd0);
    check_val("end_done_set",    32'(log_done[81]), 32'd1);
    check_val("end_done_held",   32'(log_done[99]), 32'd1);
    check_val("end_dacdat_zero", 32'(grab(82, 16)), 32'd0);
    check_val("end_addr_held",   32'(log_addr[99]), 32'd2);
    play = 1'b0;
    tick(1'b1);
    check_val("end_done_clr",    32'(done), 32'd0);
    start_play();
    run(40);
    check_val("end_restart_addr", 32'(log_addr[1]), 32'd0);
    check_val("end_restart_data", 32'(grab(1, 16)), 32'(mem(0)));
`endif

    // Pause after bit 7 at addr 5, resume from bit 0 at the next fall
    do_reset();
    end_addr = 18'd100;
    start_play();
    run(169);
    check_val("pause_addr_pre", 32'(log_addr[168]), 32'd5);
    play = 1'b0;
    run(7);
    check_val("pause_dacdat", 32'(log_dat[169]), 32'd0);
    check_val("pause_read",   32'(dif.read),     32'd0);
    play = 1'b1;
    run(40);
    check_val("pause_wait_dacdat", 32'(log_dat[185]),  32'd0);
    check_val("resume_addr",       32'(log_addr[193]), 32'd5);
    check_val("resume_data",       32'(grab(193, 16)), 32'(mem(5)));

    // Short left slot (10 bits), gap after 16 right bits, then reset mid-SHIFT
    do_reset();
    end_addr = 18'd100;
    start_play();
    for (int k = 0; k < 10; k++) tick(1'b0);
    for (int k = 0; k < 21; k++) tick(1'b1);
    for (int k = 0; k < 5; k++)  tick(1'b0);
    m = mem(0);
    check_val("short_left",  32'(grab(1, 10)),   32'(m[9:0]));
    check_val("short_addr0", 32'(log_addr[10]),  32'd0);
    check_val("short_addr1", 32'(log_addr[11]),  32'd1);
    check_val("short_right", 32'(grab(11, 16)),  32'(m));
    check_val("short_gap",   32'(grab(27, 4)),   32'd0);
    m = mem(1);
    check_val("next_left",   32'(grab(32, 4)),   32'(m[3:0]));
    check_val("pre_rst_addr", 32'(log_addr[35]), 32'd1);
    reset = 1'b1;
    tick(1'b0);
    check_val("midrst_dacdat", 32'(log_dat[36]),  32'd0);
    check_val("midrst_done",   32'(log_done[36]), 32'd0);
    check_val("midrst_addr",   32'(log_addr[36]), 32'd0);
    reset = 1'b0;
    tick(1'b0);
    tick(1'b0);
    check_val("postrst_dacdat", 32'(dif.dacdat), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dac_player.md
# dac_player

Playback counterpart of the audio-codec recorder. Reads 16-bit mono samples from the shared SRAM, starting at address 0, and serialises them onto the codec's DAC data line. Framing uses the codec's `daclrc` and `bclk`. Each sample is sent on both left and right channels. The address counter advances once per frame until `end_addr`. The block drives the SRAM address bus only while `play` is high.

## Interface
- `SAMPLE_W`, 16, bits per sample/channel slot
- `ADDR_W`, 18, SRAM word-address width
- `bclk`  in  1  codec bit clock; sole clock, all logic on posedge
- `reset`  in  1  synchronous, active-high reset
- `daclrc`  in  1  codec DAC frame clock; low = left slot, high = right slot
- `play`  in  1  playback enable (from I2C/control)
- `end_addr`  in  ADDR_W  last SRAM address to play
- `sram_rdata`  in  SAMPLE_W  SRAM read data for current `addr`
- `dacdat`  out  1  serial data to codec
- `addr`  out  ADDR_W  SRAM address; high-Z when `play`=0
- `read`  out  1  SRAM read request; equals `play` combinationally
- `done`  out  1  end-of-buffer indication

## Operation
- Edge detect: `lrc_hist[1:0]` is updated each posedge as `{lrc_hist[0], daclrc}`.
  - Falling edge: `lrc_hist`==2'b10.
  - Rising edge: `lrc_hist`==2'b01.
- States: IDLE, WAIT_LRC, SHIFT, DONE.
  - IDLE -> WAIT_LRC when `play`=1.
  - WAIT_LRC -> SHIFT on a falling edge. The shift register `sh` loads `sram_rdata`, which is also captured into `hold`.
  - In SHIFT, a rising edge reloads `sh` from `hold` for the right slot, so the same sample goes out on both channels. In the same cycle, `addr_buffer` increments.
  - The next falling edge loads a new sample.
- Bit order: LSB first. `dacdat` <= `sh[0]` in the load cycle, then `sh[cnt]` for cnt=1..15. After 16 bits, `dacdat`=0 until the next edge. This order matches the recorder's storage order, so a recording round-trips unchanged.
- An edge arriving before 16 bits are sent restarts the slot at bit 0. An edge has priority over continued shifting.
- End of buffer: when a rising edge occurs with `addr_buffer`==`end_addr`:
  - Without loop: -> DONE.
  - With loop: see Configuration.
- `end_addr`=0 plays sample 0 only.
- DONE: `dacdat`=0, `done`=1, `addr_buffer` held. `play`=0 -> IDLE with `addr_buffer` cleared to 0, so the next play restarts from 0.
- `play`=0 in WAIT_LRC/SHIFT -> IDLE next posedge, `dacdat`=0, `addr_buffer` kept. Playback pauses; reasserting `play` resumes at the next falling edge from the held address.
- `addr` = `play` ? `addr_buffer` : 'z.

## Timing
- Reset values: `dacdat`=0, `done`=0, `addr_buffer`=0, `cnt`=0, `lrc_hist`=2'b00, state IDLE. `reset` overrides everything, including mid-SHIFT.
- Latency: let edge n be the first posedge that samples `daclrc`=0. Bit 0 is driven after edge n+1, and bits 1..15 follow on edges n+2..n+16. The right slot has the same latency relative to `daclrc` rising.
- SRAM: `addr` changes at the rising-edge detect and is not sampled until the next falling-edge detect. This gives at least half a frame of settling time; no wait states.
- `dacdat` changes only on posedge `bclk`.

## Configuration
- `DAC_LOOP_EN` defined:
  - At end of buffer, `addr_buffer` wraps to 0 and playback continues; DONE is never entered.
  - `done` is a one-cycle pulse on each wrap.
- `DAC_LOOP_EN` undefined:
  - Playback stops in DONE.
  - `done` is a level that holds until `play` drops or `reset`.

## Structure
- Package `dac_pkg`:
  - state enum (IDLE, WAIT_LRC, SHIFT, DONE)
  - `SAMPLE_W`=16, `ADDR_W`=18
  - edge-pattern constants `LRC_FALL`=2'b10, `LRC_RISE`=2'b01
- Sub-module `audio_lrc_edge`: 2-bit history register with `fall`/`rise` outputs, reusable by the recorder.

## Test plan
- Reset test: hold `reset` 2 cycles with `play`=0 -> `dacdat`=0, `done`=0, `addr`=Z, `read`=0.
- Single sample: `play`=1, `sram_rdata`=16'hA5C3, 32-bclk frames -> both slots emit 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; `addr` 0->1 at the rising-edge detect.
- End stop (no `DAC_LOOP_EN`): `end_addr`=2, three frames -> `done`=1 and held, `dacdat`=0, `addr`=2. Drop then raise `play` -> restarts at `addr`=0.
- Wrap (`DAC_LOOP_EN`): `end_addr`=2 -> `addr` sequence 0,1,2,0,1; `done` high exactly 1 cycle at the 2->0 wrap.
- Pause: drop `play` after bit 7 at `addr`=5 -> `dacdat`=0 next posedge, `addr`=Z. Reassert `play` -> resumes with `addr`=5 at the next falling edge, starting from bit 0.
- Short frame and reset: a rising edge after 10 bits -> right slot starts at bit 0 with `addr`+1. Assert `reset` mid-SHIFT -> all outputs at reset values after that posedge.
